// File: rtl/mem_port_arb.sv
// Multi-port, round-robin arbitrated, byte-writable single-array memory.
// One transaction at a time: IDLE -> ACCESS (optional wait states) -> DONE.
module mem_port_arb #(
    parameter int NPORTS      = 2,
    parameter int DW          = 32,
    parameter int AW          = 7,
    parameter int WAIT_STATES = 0,
    localparam int BL         = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    re,
    input  logic [NPORTS*BL-1:0] we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] din,
    output logic [NPORTS*DW-1:0] dout,
    output logic [NPORTS-1:0]    dready,
    output logic                 busy
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [NPORTS-1:0] req;
    logic [PW-1:0]     last_grant, grant, sel;
    logic              found;
    logic              commit;
    logic [BL-1:0]     cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_din;
    logic [3:0]        cnt;
    logic [DW-1:0]     mem [2**AW];

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            req[p] = re[p] | (|we[p*BL +: BL]);
        end
    end

    // Round-robin search starting one past the last granted port.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NPORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE:   if (found) state_nxt = ACCESS;
            ACCESS: if (cnt == 4'd0) begin
                        commit    = 1'b1;
                        state_nxt = DONE;
                    end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PW'(NPORTS - 1);
            grant      <= '0;
            cmd_we     <= '0;
            cmd_addr   <= '0;
            cmd_din    <= '0;
            cnt        <= '0;
            dready     <= '0;
            dout       <= '0;
        end else begin
            dready <= '0;
            if (state == IDLE && found) begin
                grant      <= sel;
                last_grant <= sel;
                cmd_we     <= we[sel*BL +: BL];
                cmd_addr   <= addr[sel*AW +: AW];
                cmd_din    <= din[sel*DW +: DW];
                cnt        <= 4'(WAIT_STATES);
            end
            if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (commit) begin
                dready[grant] <= 1'b1;
                if (cmd_we == '0) dout[grant*DW +: DW] <= mem[cmd_addr];
            end
        end
    end

    // NOTE: the array has no reset; only the control path does, so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < BL; b++) begin
                if (cmd_we[b]) mem[cmd_addr][b*8 +: 8] <= cmd_din[b*8 +: 8];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
